// File: rtl/tlul_sram_responder_if.sv
// TL-UL bus types plus a bundle interface for the SRAM responder.
// Package: request/response structs, opcodes. Interface: h2d/d2h with modports.
package tlul_pkg;

    typedef logic [3:0] tl_a_user_t;
    typedef logic [3:0] tl_d_user_t;

    localparam tl_d_user_t TL_D_USER_DEFAULT = 4'h5;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

interface tlul_sram_responder_if;
    import tlul_pkg::*;

    tl_h2d_t h2d;
    tl_d2h_t d2h;

    modport master (output h2d, input d2h);
    modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_sram_responder.sv
// TL-UL single-outstanding SRAM responder with error counting.
// Ports: clk_i, rst_i (sync, high), tl_i (A + d_ready), tl_o (D + a_ready), err_cnt_o.
module tlul_sram_responder
    import tlul_pkg::*;
#(
    parameter int          NumWords = 16,
    parameter logic [31:0] BaseAddr = 32'h0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  tl_h2d_t    tl_i,
    output tl_d2h_t    tl_o,
    output logic [7:0] err_cnt_o
);

    localparam int AW = $clog2(NumWords);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    logic          w_a_ready;
    logic          w_accept;
    logic          w_is_get;
    logic          w_is_put;
    logic          w_align_ok;
    logic          w_range_ok;
    logic          w_mask_ok;
    logic          w_err;
    logic [3:0]    w_full_mask;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    logic [31:0] r_mem [NumWords];
    logic [2:0]  r_d_opcode;
    logic [1:0]  r_d_size;
    logic [7:0]  r_d_source;
    logic [31:0] r_d_data;
    logic        r_d_error;
    logic [7:0]  r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // a_ready is forced low during reset so nothing is accepted then.
    always_comb begin
        w_state_nxt = r_state;
        w_a_ready   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_a_ready = !rst_i;
                if (tl_i.a_valid && !rst_i) w_state_nxt = RESP;
            end
            RESP: begin
                if (tl_i.d_ready) w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = tl_i.a_valid && w_a_ready;
    assign w_is_get = tl_i.a_opcode == Get;
    assign w_is_put = (tl_i.a_opcode == PutFullData) ||
                      (tl_i.a_opcode == PutPartialData);
    assign w_idx    = tl_i.a_address[AW+1:2];

    always_comb begin
        w_align_ok  = 1'b0;
        w_full_mask = 4'hF;
        unique case (tl_i.a_size)
            2'd0: begin
                w_align_ok  = 1'b1;
                w_full_mask = 4'b0001 << tl_i.a_address[1:0];
            end
            2'd1: begin
                w_align_ok  = !tl_i.a_address[0];
                w_full_mask = 4'b0011 << tl_i.a_address[1:0];
            end
            2'd2: begin
                w_align_ok  = tl_i.a_address[1:0] == 2'b00;
                w_full_mask = 4'hF;
            end
            2'd3: begin
                w_align_ok  = 1'b0;
                w_full_mask = 4'hF;
            end
        endcase
    end

    // Base is aligned to the window size, so an upper-bit compare suffices.
    assign w_range_ok = tl_i.a_address[31:AW+2] == BaseAddr[31:AW+2];
    assign w_mask_ok  = (tl_i.a_opcode != PutFullData) ||
                        (tl_i.a_mask == w_full_mask);
    assign w_err      = !(w_is_get || w_is_put) || !w_align_ok ||
                        !w_range_ok || !w_mask_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) r_mem[i] <= 32'h0;
        end else if (w_accept && w_is_put && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (tl_i.a_mask[b])
                    r_mem[w_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_d_opcode <= 3'h0;
            r_d_size   <= 2'h0;
            r_d_source <= 8'h0;
            r_d_data   <= 32'h0;
            r_d_error  <= 1'b0;
        end else if (w_accept) begin
            r_d_opcode <= w_is_get ? AccessAckData : AccessAck;
            r_d_size   <= tl_i.a_size;
            r_d_source <= tl_i.a_source;
            r_d_error  <= w_err;
            if (w_err)         r_d_data <= 32'hFFFF_FFFF;
            else if (w_is_get) r_d_data <= r_mem[w_idx];
            else               r_d_data <= 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_err_cnt <= 8'h0;
        else if (w_accept && w_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = r_state == RESP;
        tl_o.d_opcode = r_d_opcode;
        tl_o.d_size   = r_d_size;
        tl_o.d_source = r_d_source;
        tl_o.d_data   = r_d_data;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.d_error  = r_d_error;
        tl_o.a_ready  = w_a_ready;
    end

    assign err_cnt_o = r_err_cnt;
    assign w_unused  = ^{tl_i.a_param, tl_i.a_user};

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Self-checking bench for tlul_sram_responder: model + directed vectors.
// Ports driven through tlul_sram_responder_if; checks on the falling edge.
module tb_tlul_sram_responder;
    import tlul_pkg::*;

    localparam int NW = 16;
    localparam logic [31:0] BASE = 32'h0;

    logic       clk;
    logic       rst;
    logic [7:0] err_cnt;
    int         errors;
    int         checks;
    logic [7:0] src_n;

    tlul_sram_responder_if bus ();

    tlul_sram_responder #(
        .NumWords (NW),
        .BaseAddr (BASE)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .tl_i      (bus.h2d),
        .tl_o      (bus.d2h),
        .err_cnt_o (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory image, pending response, error count.
    logic [31:0] mm [NW];
    bit          m_ok;
    bit          m_busy;
    int          m_cnt;
    logic [2:0]  e_op;
    logic        e_err;
    logic [31:0] e_data;
    logic [1:0]  e_size;
    logic [7:0]  e_src;

    task automatic model_accept(input tl_h2d_t a);
        int     nb;
        int     fm;
        longint ad;
        bit     bad;
        ad  = longint'(a.a_address);
        bad = !(a.a_opcode inside {3'h0, 3'h1, 3'h4});
        bad = bad || a.a_size > 2;
        bad = bad || (ad % (longint'(1) << a.a_size)) != 0;
        bad = bad || ad < longint'(BASE) || ad >= longint'(BASE) + 4 * NW;
        if (a.a_opcode == 3'h0 && a.a_size <= 2) begin
            nb  = 1 << a.a_size;
            fm  = ((1 << nb) - 1) << (ad % 4);
            bad = bad || int'(a.a_mask) != fm;
        end
        e_op   = (a.a_opcode == 3'h4) ? 3'h1 : 3'h0;
        e_err  = bad;
        e_size = a.a_size;
        e_src  = a.a_source;
        if (bad) begin
            e_data = 32'hFFFF_FFFF;
            if (m_cnt < 255) m_cnt++;
        end else if (a.a_opcode == 3'h4) begin
            e_data = mm[(ad - BASE) / 4];
        end else begin
            e_data = 32'h0;
            for (int b = 0; b < 4; b++)
                if (a.a_mask[b])
                    mm[(ad - BASE) / 4][8*b +: 8] = a.a_data[8*b +: 8];
        end
    endtask

    // Compare outputs to the model, then advance it to the next rising edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("a_ready", 32'(bus.d2h.a_ready), 32'(!m_busy && !rst));
            chk("d_valid", 32'(bus.d2h.d_valid), 32'(m_busy));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (m_busy) begin
                chk("d_opcode", 32'(bus.d2h.d_opcode), 32'(e_op));
                chk("d_error", 32'(bus.d2h.d_error), 32'(e_err));
                chk("d_data", bus.d2h.d_data, e_data);
                chk("d_size", 32'(bus.d2h.d_size), 32'(e_size));
                chk("d_source", 32'(bus.d2h.d_source), 32'(e_src));
                chk("d_sink", 32'(bus.d2h.d_sink), 32'h0);
                chk("d_user", 32'(bus.d2h.d_user), 32'(TL_D_USER_DEFAULT));
            end
        end
        if (rst) begin
            m_ok   = 1'b1;
            m_busy = 1'b0;
            m_cnt  = 0;
            for (int i = 0; i < NW; i++) mm[i] = 32'h0;
        end else if (m_ok) begin
            if (m_busy) begin
                if (bus.h2d.d_ready) m_busy = 1'b0;
            end else if (bus.h2d.a_valid) begin
                model_accept(bus.h2d);
                m_busy = 1'b1;
            end
        end
    end

    task automatic set_a(input logic [2:0] op, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data);
        src_n = src_n + 8'd1;
        bus.h2d.a_valid   = 1'b1;
        bus.h2d.a_opcode  = op;
        bus.h2d.a_param   = 3'h0;
        bus.h2d.a_size    = sz;
        bus.h2d.a_source  = src_n;
        bus.h2d.a_address = addr;
        bus.h2d.a_mask    = mask;
        bus.h2d.a_data    = data;
        bus.h2d.a_user    = 4'hC;
    endtask

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (bus.d2h.a_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(acc), 32'h1);
    endtask

    task automatic xact(input logic [2:0] op, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, output logic [31:0] rd,
                        output logic er, output logic [2:0] opc);
        bit got;
        bus.h2d.d_ready = 1'b1;
        set_a(op, sz, addr, mask, data);
        wait_accept();
        bus.h2d.a_valid = 1'b0;
        got = 1'b0;
        rd  = 32'hx;
        er  = 1'bx;
        opc = 3'hx;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.d2h.d_valid) begin
                rd  = bus.d2h.d_data;
                er  = bus.d2h.d_error;
                opc = bus.d2h.d_opcode;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("resp_timeout", 32'(got), 32'h1);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [2:0]  opc;

    initial begin
        errors = 0;
        checks = 0;
        src_n  = 8'h0;
        m_ok   = 1'b0;
        m_busy = 1'b0;
        m_cnt  = 0;
        rst    = 1'b1;
        bus.h2d = '0;
        bus.h2d.d_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_a_ready", 32'(bus.d2h.a_ready), 32'h1);
        chk("rst_d_valid", 32'(bus.d2h.d_valid), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_d_data", bus.d2h.d_data, 32'h0);
        chk("rst_d_user", 32'(bus.d2h.d_user), 32'(TL_D_USER_DEFAULT));
        @(posedge clk);
        #1;

        xact(3'h0, 2'd2, 32'h8, 4'hF, 32'hDEADBEEF, rd, er, opc);
        chk("put_opcode", 32'(opc), 32'h0);
        chk("put_error", 32'(er), 32'h0);
        xact(3'h4, 2'd2, 32'h8, 4'h0, 32'h0, rd, er, opc);
        chk("get_opcode", 32'(opc), 32'h1);
        chk("get_data", rd, 32'hDEADBEEF);

        xact(3'h1, 2'd2, 32'h8, 4'b0010, 32'h0000_5500, rd, er, opc);
        xact(3'h4, 2'd2, 32'h8, 4'hF, 32'h0, rd, er, opc);
        chk("partial_data", rd, 32'hDEAD55EF);

        xact(3'h4, 2'd2, 32'(4 * NW), 4'hF, 32'h0, rd, er, opc);
        chk("oor_error", 32'(er), 32'h1);
        chk("oor_data", rd, 32'hFFFFFFFF);
        chk("oor_cnt", 32'(err_cnt), 32'h1);

        xact(3'h2, 2'd2, 32'h4, 4'hF, 32'h0, rd, er, opc);
        chk("badop_opcode", 32'(opc), 32'h0);
        chk("badop_error", 32'(er), 32'h1);
        chk("badop_cnt", 32'(err_cnt), 32'h2);

        xact(3'h4, 2'd2, 32'h2, 4'hF, 32'h0, rd, er, opc);
        chk("misalign_error", 32'(er), 32'h1);

        xact(3'h0, 2'd0, 32'h5, 4'b0010, 32'h0000_7700, rd, er, opc);
        chk("byte_put_error", 32'(er), 32'h0);
        xact(3'h0, 2'd1, 32'h4, 4'b0011, 32'h1111_2222, rd, er, opc);
        chk("half_put_error", 32'(er), 32'h0);
        xact(3'h0, 2'd2, 32'h4, 4'b0111, 32'hAAAA_AAAA, rd, er, opc);
        chk("badmask_error", 32'(er), 32'h1);
        xact(3'h4, 2'd3, 32'h0, 4'hF, 32'h0, rd, er, opc);
        chk("size3_error", 32'(er), 32'h1);
        xact(3'h4, 2'd2, 32'h4, 4'h0, 32'h0, rd, er, opc);
        chk("sub_word_data", rd, 32'h0000_2222);
        chk("err_cnt_5", 32'(err_cnt), 32'h5);

        bus.h2d.d_ready = 1'b0;
        set_a(3'h4, 2'd2, 32'h8, 4'hF, 32'h0);
        wait_accept();
        set_a(3'h0, 2'd2, 32'h8, 4'hF, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_d_valid", 32'(bus.d2h.d_valid), 32'h1);
            chk("bp_a_ready", 32'(bus.d2h.a_ready), 32'h0);
            chk("bp_d_data", bus.d2h.d_data, 32'hDEAD55EF);
            @(posedge clk);
            #1;
        end
        bus.h2d.d_ready = 1'b1;
        bus.h2d.a_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_retire_a_ready", 32'(bus.d2h.a_ready), 32'h1);
        chk("bp_retire_d_valid", 32'(bus.d2h.d_valid), 32'h0);
        @(posedge clk);
        #1;
        xact(3'h4, 2'd2, 32'h8, 4'hF, 32'h0, rd, er, opc);
        chk("bp_no_write", rd, 32'hDEAD55EF);

        bus.h2d.d_ready = 1'b0;
        set_a(3'h4, 2'd2, 32'h8, 4'hF, 32'h0);
        wait_accept();
        bus.h2d.a_valid = 1'b0;
        @(negedge clk);
        chk("mid_d_valid", 32'(bus.d2h.d_valid), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("in_rst_a_ready", 32'(bus.d2h.a_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_d_valid", 32'(bus.d2h.d_valid), 32'h0);
        chk("post_rst_a_ready", 32'(bus.d2h.a_ready), 32'h1);
        chk("post_rst_cnt", 32'(err_cnt), 32'h0);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        xact(3'h4, 2'd2, 32'h8, 4'hF, 32'h0, rd, er, opc);
        chk("post_rst_data", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlul_sram_responder.md
TLUL_SRAM_RESPONDER -- requirements
Module: tlul_sram_responder

Interface
REQ-001 SHALL have parameter NumWords, default 16, number of 32-bit storage words (power of 2, 2..256).
REQ-002 SHALL have parameter BaseAddr, default 32'h0, byte address of word 0 (aligned to 4*NumWords).
REQ-003 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tl_i  input  tlul_pkg::tl_h2d_t  TL-UL A channel from host plus d_ready.
REQ-006 SHALL have port tl_o  output  tlul_pkg::tl_d2h_t  TL-UL D channel to host plus a_ready.
REQ-007 SHALL have port err_cnt_o  output  8  count of error responses issued, saturating at 8'hFF.

Function
REQ-008 SHALL implement a TL-UL device responder with two states: IDLE (no response held) and RESP (response held on D channel).
REQ-009 SHALL drive tl_o.a_ready = 1 in IDLE and 0 in RESP. At most one transaction outstanding.
REQ-010 SHALL accept a request on a rising edge where tl_i.a_valid and tl_o.a_ready are both 1, then move IDLE->RESP.
REQ-011 SHALL drive tl_o.d_valid = 1 exactly in RESP. Latency from acceptance edge to d_valid is 1 cycle.
REQ-012 SHALL hold all D-channel fields stable while d_valid=1 and d_ready=0.
REQ-013 SHALL move RESP->IDLE on an edge with d_valid and tl_i.d_ready both 1. a_ready rises the next cycle; no same-cycle accept-on-retire.
REQ-014 SHALL set d_source = captured a_source, d_size = captured a_size, d_sink = 0, d_user = tlul_pkg::TL_D_USER_DEFAULT. a_user is ignored.
REQ-015 SHALL set d_opcode per request type:
- AccessAckData (3'h1) for Get (3'h4).
- AccessAck (3'h0) for PutFullData (3'h0), PutPartialData (3'h1) and any unsupported opcode.
REQ-016 SHALL flag a request as error (d_error=1) if any of these hold:
- opcode not in {0,1,4};
- a_size > 2;
- a_address not aligned to 2^a_size;
- a_address outside [BaseAddr, BaseAddr+4*NumWords);
- PutFullData with a_mask not equal to the full contiguous mask for a_size/a_address[1:0].
REQ-017 SHALL, for an error request: perform no storage write; set d_data = 32'hFFFF_FFFF; increment err_cnt_o once on acceptance, saturating.
REQ-018 SHALL, for a non-error Get: return the full 32-bit word at index (a_address-BaseAddr)>>2 in d_data, captured at acceptance. Mask is ignored.
REQ-019 SHALL, for a non-error Put: write byte lanes where a_mask bit is 1, on the acceptance edge; leave other lanes unchanged; set d_data = 0.
REQ-020 SHALL make a write visible to a Get accepted on any later edge.
REQ-021 SHALL ignore a_valid while in RESP; the host is expected to hold the request.
REQ-022 SHALL leave storage unchanged when a_valid=1 and a_ready=0.

Reset
REQ-023 SHALL, on any edge with rst_i=1:
- enter IDLE;
- drive d_valid=0, a_ready=1 from the next cycle;
- clear all D-channel fields to 0 except d_user (default);
- set err_cnt_o=0;
- clear all storage words to 0.
REQ-024 SHALL discard a held response when rst_i asserts in RESP. No d_valid appears after reset release until a new request is accepted.
REQ-025 SHALL drive a_ready=0 on any cycle where rst_i=1.

Verification
REQ-026 Put/Get, with BaseAddr=0: PutFullData addr 0x8 data 32'hDEADBEEF mask 4'hF size 2 -> next cycle d_valid, d_opcode 0, d_error 0. Then Get addr 0x8 -> d_opcode 1, d_data 32'hDEADBEEF.
REQ-027 Partial write: word 0x8 = 32'hDEADBEEF, then PutPartialData addr 0x8 mask 4'b0010 data 32'h0000_5500 -> Get returns 32'hDEAD55EF.
REQ-028 Errors:
- Get addr 4*NumWords -> d_error 1, d_data 32'hFFFFFFFF, err_cnt_o 1.
- Opcode 3'h2 -> AccessAck, d_error 1, err_cnt_o 2.
- Get size 2 addr 0x2 -> d_error 1.
REQ-029 Backpressure: d_ready=0 for 5 cycles after a Get -> d_valid and fields stable, a_ready 0 throughout, a second a_valid not accepted. d_ready=1 -> retire; a_ready=1 the following cycle.
REQ-030 Reset mid-response: rst_i pulsed while d_valid=1 -> d_valid 0, a_ready 1, err_cnt_o 0, and a Get of the previously written address returns 0.
